// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, issues instruction-memory reads and queues {instr, pc} for decode.
// Optional INSTR_FETCH_STATS_EN adds saturating FetchCount/FlushCount output ports.

module instruction_fetch_checker #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic          read_en,
  input logic          branch_taken,
  input logic [CW-1:0] count,
  input logic [CW:0]   occupancy
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // A push into a full queue means the issue throttle is broken.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == DEPTH_C)));
  assert property (@(posedge clk) disable iff (!rst_n) occupancy <= {1'b0, DEPTH_C});
  assert property (@(posedge clk) disable iff (!rst_n) !(read_en && branch_taken));
endmodule

module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] ReadAddr,
  output logic        ReadEn,
  input  logic [31:0] Instruction,
  input  logic        BranchTaken,
  input  logic [63:0] BranchTarget,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrOut,
  output logic [63:0] InstrPC
`ifdef INSTR_FETCH_STATS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount
`endif
);

  localparam int unsigned   PW         = $clog2(DEPTH);
  localparam int unsigned   CW         = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [63:0]   PC_MASK    = ~64'h3;
  localparam logic [63:0]   RESET_PC_A = RESET_PC & PC_MASK;

  logic [63:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [63:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [63:0]   pc_mem_q    [DEPTH];
  logic          valid_q, valid_d;
  logic [31:0]   out_instr_q, out_instr_d;
  logic [63:0]   out_pc_q, out_pc_d;
  logic [CW:0]   occupancy_s;
  logic          issue_s;
  logic          push_s;
  logic          pop_s;

  // Handshake decisions; a redirect suppresses issue, push and pop alike.
  always_comb begin
    occupancy_s = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    if (rst_n && !BranchTaken && (occupancy_s < {1'b0, DEPTH_C})) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    push_s = inflight_q && !BranchTaken;
    pop_s  = valid_q && InstrReady && !BranchTaken;
  end

  // PC, in-flight tracking and queue pointer/count next state.
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (BranchTaken) begin
      pc_d     = BranchTarget & PC_MASK;
      count_d  = {CW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
    end else begin
      if (issue_s) begin
        pc_d = pc_q + 64'd4;
      end else begin
        pc_d = pc_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    inflight_d = issue_s;
    if (issue_s) begin
      inflight_pc_d = pc_q;
    end else begin
      inflight_pc_d = inflight_pc_q;
    end
  end

  // Head register: bypass the word being written when it becomes the new head.
  always_comb begin
    valid_d     = (count_d != {CW{1'b0}});
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    if (valid_d) begin
      if (push_s && (rd_ptr_d == wr_ptr_q)) begin
        out_instr_d = Instruction;
        out_pc_d    = inflight_pc_q;
      end else begin
        out_instr_d = instr_mem_q[rd_ptr_d];
        out_pc_d    = pc_mem_q[rd_ptr_d];
      end
    end else begin
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
    end
  end

  // Control and head state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC_A;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 64'h0;
      count_q       <= {CW{1'b0}};
      rd_ptr_q      <= {PW{1'b0}};
      wr_ptr_q      <= {PW{1'b0}};
      valid_q       <= 1'b0;
      out_instr_q   <= 32'h0;
      out_pc_q      <= 64'h0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      valid_q       <= valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
    end
  end

  // Queue storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= 32'h0;
        pc_mem_q[i]    <= 64'h0;
      end
    end else if (push_s) begin
      instr_mem_q[wr_ptr_q] <= Instruction;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign ReadEn     = issue_s;
  assign ReadAddr   = pc_q;
  assign InstrValid = valid_q;
  assign InstrOut   = out_instr_q;
  assign InstrPC    = out_pc_q;

`ifdef INSTR_FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    if (pop_s && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (BranchTaken && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

  instruction_fetch_checker #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_checker (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push_s),
    .read_en      (issue_s),
    .branch_taken (BranchTaken),
    .count        (count_q),
    .occupancy    (occupancy_s)
  );

endmodule
